// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - parametrised full-duplex UART transceiver
// TX frames words from a ready/valid port; RX oversamples, majority-votes and flags errors.
module uart_xcvr #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVS / 2);
  localparam logic [TW-1:0] TICK_S2   = TW'(OVS / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------- transmitter ----------------
  state_e               tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_div_q, tx_div_d;
  logic [DIV_W-1:0]     tx_dcnt_q, tx_dcnt_d;
  logic [TW-1:0]        tx_tcnt_q, tx_tcnt_d;
  logic [3:0]           tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_dcnt_q == tx_div_q) && (tx_tcnt_q == TICK_LAST);
  assign tx_ready   = (tx_state_q == S_IDLE);
  assign tx         = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_dcnt_d  = tx_dcnt_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = 1'b1;

    if (tx_state_q != S_IDLE) begin
      if (tx_dcnt_q == tx_div_q) begin
        tx_dcnt_d = '0;
        tx_tcnt_d = (tx_tcnt_q == TICK_LAST) ? '0 : tx_tcnt_q + TW'(1);
      end else begin
        tx_dcnt_d = tx_dcnt_q + DIV_W'(1);
      end
    end

    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_state_d = S_START;
          tx_div_d   = baud_div;
          tx_sh_d    = tx_data;
          tx_par_d   = (PARITY == 1) ? ~(^tx_data) : ^tx_data;
          tx_dcnt_d  = '0;
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
        end
      end
      S_START: begin
        if (tx_bit_end) tx_state_d = S_DATA;
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bcnt_q == DATA_LAST) begin
            tx_bcnt_d  = '0;
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            tx_bcnt_d = tx_bcnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tx_bit_end) tx_state_d = S_STOP;
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (tx_bcnt_q == STOP_LAST) tx_state_d = S_IDLE;
          else                        tx_bcnt_d  = tx_bcnt_q + 4'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_sh_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_div_q   <= '0;
      tx_dcnt_q  <= '0;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_dcnt_q  <= tx_dcnt_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- receiver ----------------
  state_e               rx_state_q, rx_state_d;
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rx_armed_q, rx_armed_d;
  logic [DIV_W-1:0]     rx_div_q, rx_div_d;
  logic [DIV_W-1:0]     rx_dcnt_q, rx_dcnt_d;
  logic [TW-1:0]        rx_tcnt_q, rx_tcnt_d;
  logic [3:0]           rx_bcnt_q, rx_bcnt_d;
  logic [1:0]           rx_samp_q, rx_samp_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_s, rx_dend, rx_bit_end, rx_vote_now, rx_vote, rx_par_exp;

  assign rx_s        = rx_sync_q[1];
  assign rx_dend     = (rx_dcnt_q == rx_div_q) && (rx_state_q != S_IDLE);
  assign rx_bit_end  = rx_dend && (rx_tcnt_q == TICK_LAST);
  assign rx_vote_now = rx_dend && (rx_tcnt_q == TICK_S2);
  assign rx_vote     = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_s) |
                       (rx_samp_q[1] & rx_s);
  assign rx_par_exp  = (PARITY == 1) ? ~(^rx_sh_q) : ^rx_sh_q;

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sync_d  = {rx_sync_q[0], rx};
    rx_armed_d = rx_armed_q;
    rx_div_d   = rx_div_q;
    rx_dcnt_d  = rx_dcnt_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_samp_d  = rx_samp_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ferr_d  = 1'b0;
      rx_ovr_d   = 1'b0;
    end

    if (rx_state_q != S_IDLE) begin
      if (rx_dend) begin
        rx_dcnt_d = '0;
        rx_tcnt_d = (rx_tcnt_q == TICK_LAST) ? '0 : rx_tcnt_q + TW'(1);
        if (rx_tcnt_q == TICK_S0) rx_samp_d[0] = rx_s;
        if (rx_tcnt_q == TICK_S1) rx_samp_d[1] = rx_s;
      end else begin
        rx_dcnt_d = rx_dcnt_q + DIV_W'(1);
      end
    end

    case (rx_state_q)
      S_IDLE: begin
        // A low line only counts as a start edge once a high has been seen (break handling).
        if (rx_s) begin
          rx_armed_d = 1'b1;
        end else if (rx_armed_q) begin
          rx_state_d = S_START;
          rx_armed_d = 1'b0;
          rx_div_d   = baud_div;
          rx_dcnt_d  = '0;
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
        end
      end
      S_START: begin
        if (rx_vote_now && rx_vote) rx_state_d = S_IDLE;
        else if (rx_bit_end)        rx_state_d = S_DATA;
      end
      S_DATA: begin
        if (rx_vote_now) rx_sh_d = {rx_vote, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_bcnt_q == DATA_LAST) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                        rx_bcnt_d  = rx_bcnt_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (rx_vote_now) rx_par_d   = rx_vote;
        if (rx_bit_end)  rx_state_d = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop so the next start edge is caught within half a bit.
        if (rx_vote_now) begin
          rx_state_d = S_IDLE;
          if (!rx_valid_q || rx_ready) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            rx_perr_d  = (PARITY != 0) && (rx_par_q != rx_par_exp);
            rx_ferr_d  = ~rx_vote;
          end else begin
            rx_ovr_d = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_sync_q  <= 2'b11;
      rx_armed_q <= 1'b0;
      rx_div_q   <= '0;
      rx_dcnt_q  <= '0;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_samp_q  <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync_q  <= rx_sync_d;
      rx_armed_q <= rx_armed_d;
      rx_div_q   <= rx_div_d;
      rx_dcnt_q  <= rx_dcnt_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_samp_q  <= rx_samp_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule
